// File: rtl/control_unit_11_pkg.sv
// Shared constants, state encoding and control bundle
// for the multicycle MIPS main control unit.
package control_unit_11_pkg;

    localparam int OP_W   = 6;
    localparam int ALUC_W = 3;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_ANDI = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI  = 6'b001101;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;

    localparam logic [ALUC_W-1:0] ALUC_RTYPE = 3'b000;
    localparam logic [ALUC_W-1:0] ALUC_ADD   = 3'b001;
    localparam logic [ALUC_W-1:0] ALUC_AND   = 3'b011;
    localparam logic [ALUC_W-1:0] ALUC_OR    = 3'b100;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SEXT = 2'b10;
    localparam logic [1:0] SRCB_ZEXT = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_JUMP = 2'b01;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_ADD = 4'd4,
        S_EXEC_AND = 4'd5,
        S_EXEC_OR  = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_R     = 4'd9,
        S_WB_I     = 4'd10,
        S_WB_MEM   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    typedef struct packed {
        logic [ALUC_W-1:0] aluc;
        logic              alu_src_a;
        logic [1:0]        alu_src_b;
        logic              pc_we;
        logic [1:0]        pc_src;
        logic              iord;
        logic              mem_rd;
        logic              mem_wr;
        logic              ir_we;
        logic              reg_we;
        logic              reg_dst;
        logic              mem_to_reg;
    } ctrl_t;

endpackage

// File: rtl/control_unit_11_if.sv
// Control bus between the main control FSM and the
// datapath / memory side.
interface control_unit_11_if;
    import control_unit_11_pkg::*;

    logic [OP_W-1:0]   opcode;
    logic              mem_ready;
    logic [ALUC_W-1:0] aluc;
    logic              alu_src_a;
    logic [1:0]        alu_src_b;
    logic              pc_we;
    logic [1:0]        pc_src;
    logic              iord;
    logic              mem_rd;
    logic              mem_wr;
    logic              ir_we;
    logic              reg_we;
    logic              reg_dst;
    logic              mem_to_reg;
    logic              illegal;

    modport master (
        input  opcode, mem_ready,
        output aluc, alu_src_a, alu_src_b, pc_we, pc_src,
        output iord, mem_rd, mem_wr, ir_we, reg_we,
        output reg_dst, mem_to_reg, illegal
    );

    modport slave (
        output opcode, mem_ready,
        input  aluc, alu_src_a, alu_src_b, pc_we, pc_src,
        input  iord, mem_rd, mem_wr, ir_we, reg_we,
        input  reg_dst, mem_to_reg, illegal
    );

endinterface

// File: rtl/control_unit_11_opcode_class.sv
// Opcode classifier: picks the EXEC state after DECODE
// and the successor of the shared add-execute state.
module opcode_class_11
    import control_unit_11_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output state_t          exec_state,
    output state_t          add_next,
    output logic            legal
);

    always_comb begin
        exec_state = S_TRAP;
        add_next   = S_WB_I;
        legal      = 1'b1;
        unique case (opcode)
            OP_R:    exec_state = S_EXEC_R;
            OP_LW: begin
                exec_state = S_EXEC_ADD;
                add_next   = S_MEM_RD;
            end
            OP_SW: begin
                exec_state = S_EXEC_ADD;
                add_next   = S_MEM_WR;
            end
            OP_ADDI: exec_state = S_EXEC_ADD;
            OP_ANDI: exec_state = S_EXEC_AND;
            OP_ORI:  exec_state = S_EXEC_OR;
            OP_J:    exec_state = S_JUMP;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit_11.sv
// Multicycle MIPS main control FSM: sequences fetch,
// decode, execute, memory and write-back phases.
module control_unit_11
    import control_unit_11_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    control_unit_11_if.master  bus
);

    state_t state;
    state_t next;
    state_t exec_state;
    state_t add_next;
    logic   legal;
    logic   illegal_q;
    ctrl_t  ctrl;

    opcode_class_11 u_class (
        .opcode     (bus.opcode),
        .exec_state (exec_state),
        .add_next   (add_next),
        .legal      (legal)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state     <= S_RESET;
            illegal_q <= 1'b0;
        end else begin
            state <= next;
            if (next == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        next = state;
        ctrl = '0;
        unique case (state)
            S_RESET: next = S_FETCH;
            S_FETCH: begin
                ctrl.mem_rd    = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.aluc      = ALUC_ADD;
                if (bus.mem_ready) begin
                    ctrl.ir_we  = 1'b1;
                    ctrl.pc_we  = 1'b1;
                    ctrl.pc_src = PCSRC_ALU;
                    next        = S_DECODE;
                end
            end
            S_DECODE: next = legal ? exec_state : S_TRAP;
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.aluc      = ALUC_RTYPE;
                next           = S_WB_R;
            end
            S_EXEC_ADD: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_SEXT;
                ctrl.aluc      = ALUC_ADD;
                next           = add_next;
            end
            S_EXEC_AND: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_ZEXT;
                ctrl.aluc      = ALUC_AND;
                next           = S_WB_I;
            end
            S_EXEC_OR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_ZEXT;
                ctrl.aluc      = ALUC_OR;
                next           = S_WB_I;
            end
            S_MEM_RD: begin
                ctrl.mem_rd = 1'b1;
                ctrl.iord   = 1'b1;
                if (bus.mem_ready)
                    next = S_WB_MEM;
            end
            S_MEM_WR: begin
                ctrl.mem_wr = 1'b1;
                ctrl.iord   = 1'b1;
                if (bus.mem_ready)
                    next = S_FETCH;
            end
            S_WB_R: begin
                ctrl.reg_we  = 1'b1;
                ctrl.reg_dst = 1'b1;
                next         = S_FETCH;
            end
            S_WB_I: begin
                ctrl.reg_we = 1'b1;
                next        = S_FETCH;
            end
            S_WB_MEM: begin
                ctrl.reg_we     = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                next            = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_we  = 1'b1;
                ctrl.pc_src = PCSRC_JUMP;
                next        = S_FETCH;
            end
            S_TRAP: next = S_TRAP;
            default: next = S_RESET;
        endcase
        // Masking during reset keeps an aborted instruction from
        // committing a PC, IR or register write on the reset edge.
        if (!i_rst_n)
            ctrl = '0;
    end

    assign bus.aluc       = ctrl.aluc;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.pc_we      = ctrl.pc_we;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.iord       = ctrl.iord;
    assign bus.mem_rd     = ctrl.mem_rd;
    assign bus.mem_wr     = ctrl.mem_wr;
    assign bus.ir_we      = ctrl.ir_we;
    assign bus.reg_we     = ctrl.reg_we;
    assign bus.reg_dst    = ctrl.reg_dst;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_control_unit_11.sv
// Directed bench for control_unit_11: cycle-by-cycle
// vector table plus hand-written stall/reset/trap sequences.
module tb_control_unit_11;

    typedef struct packed {
        logic [2:0] aluc;
        logic       src_a;
        logic [1:0] src_b;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_we;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       illegal;
    } outs_t;

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       rdy;
        outs_t      want;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    vec_t tbl[$];

    control_unit_11_if bus ();

    control_unit_11 dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic outs_t o_zero(input logic ill);
        outs_t o = '0;
        o.illegal = ill;
        return o;
    endfunction

    function automatic outs_t o_fetch(input logic r);
        outs_t o = '0;
        o.mem_rd = 1'b1;
        o.src_b  = 2'b01;
        o.aluc   = 3'b001;
        o.ir_we  = r;
        o.pc_we  = r;
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [2:0] a,
                                     input logic [1:0] b);
        outs_t o = '0;
        o.src_a = 1'b1;
        o.src_b = b;
        o.aluc  = a;
        return o;
    endfunction

    function automatic outs_t o_wb(input logic d,
                                   input logic m);
        outs_t o = '0;
        o.reg_we     = 1'b1;
        o.reg_dst    = d;
        o.mem_to_reg = m;
        return o;
    endfunction

    function automatic outs_t o_jump();
        outs_t o = '0;
        o.pc_we  = 1'b1;
        o.pc_src = 2'b01;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic wr);
        outs_t o = '0;
        o.iord   = 1'b1;
        o.mem_rd = ~wr;
        o.mem_wr = wr;
        return o;
    endfunction

    task automatic push(input logic r, input logic [5:0] op,
                        input logic rdy, input outs_t w);
        vec_t v;
        v.rst_n = r;
        v.op    = op;
        v.rdy   = rdy;
        v.want  = w;
        tbl.push_back(v);
    endtask

    task automatic step(input logic r, input logic [5:0] op,
                        input logic rdy, input outs_t want,
                        input string tag);
        outs_t got;
        @(negedge clk);
        rst_n         = r;
        bus.opcode    = op;
        bus.mem_ready = rdy;
        #1;
        got.aluc       = bus.aluc;
        got.src_a      = bus.alu_src_a;
        got.src_b      = bus.alu_src_b;
        got.pc_we      = bus.pc_we;
        got.pc_src     = bus.pc_src;
        got.iord       = bus.iord;
        got.mem_rd     = bus.mem_rd;
        got.mem_wr     = bus.mem_wr;
        got.ir_we      = bus.ir_we;
        got.reg_we     = bus.reg_we;
        got.reg_dst    = bus.reg_dst;
        got.mem_to_reg = bus.mem_to_reg;
        got.illegal    = bus.illegal;
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    localparam logic [5:0] R  = 6'b000000;
    localparam logic [5:0] LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011;
    localparam logic [5:0] AI = 6'b001000;
    localparam logic [5:0] NI = 6'b001100;
    localparam logic [5:0] OI = 6'b001101;
    localparam logic [5:0] J  = 6'b000010;
    localparam logic [5:0] BD = 6'b111111;

    initial begin
        // reset exit, then R / ORI / ANDI / ADDI / J / SW
        push(1, R, 0, o_zero(0));
        push(1, R, 1, o_fetch(1));
        push(1, R, 1, o_zero(0));
        push(1, R, 1, o_exec(3'b000, 2'b00));
        push(1, R, 0, o_wb(1, 0));
        push(1, OI, 1, o_fetch(1));
        push(1, OI, 0, o_zero(0));
        push(1, OI, 1, o_exec(3'b100, 2'b11));
        push(1, OI, 0, o_wb(0, 0));
        push(1, NI, 1, o_fetch(1));
        push(1, NI, 0, o_zero(0));
        push(1, NI, 0, o_exec(3'b011, 2'b11));
        push(1, NI, 0, o_wb(0, 0));
        push(1, AI, 1, o_fetch(1));
        push(1, AI, 0, o_zero(0));
        push(1, AI, 0, o_exec(3'b001, 2'b10));
        push(1, AI, 0, o_wb(0, 0));
        push(1, J, 1, o_fetch(1));
        push(1, J, 1, o_zero(0));
        push(1, J, 1, o_jump());
        push(1, SW, 1, o_fetch(1));
        push(1, SW, 0, o_zero(0));
        push(1, SW, 0, o_exec(3'b001, 2'b10));
        push(1, SW, 1, o_mem(1));

        rst_n         = 1'b0;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);

        foreach (tbl[i])
            step(tbl[i].rst_n, tbl[i].op, tbl[i].rdy,
                 tbl[i].want, $sformatf("tbl[%0d]", i));

        // LW: 3 fetch wait cycles, 2 read wait cycles, 10 total
        for (int k = 0; k < 3; k++)
            step(1, LW, 0, o_fetch(0), "lw_fetch_wait");
        step(1, LW, 1, o_fetch(1), "lw_fetch_go");
        step(1, LW, 0, o_zero(0), "lw_decode");
        step(1, LW, 1, o_exec(3'b001, 2'b10), "lw_exec");
        for (int k = 0; k < 2; k++)
            step(1, LW, 0, o_mem(0), "lw_rd_wait");
        step(1, LW, 1, o_mem(0), "lw_rd_go");
        step(1, LW, 0, o_wb(0, 1), "lw_wb");

        // reset held two cycles while a store is stalled
        step(1, SW, 1, o_fetch(1), "rst_fetch");
        step(1, SW, 0, o_zero(0), "rst_decode");
        step(1, SW, 0, o_exec(3'b001, 2'b10), "rst_exec");
        step(1, SW, 0, o_mem(1), "rst_memwr");
        step(0, SW, 1, o_zero(0), "rst_hold0");
        step(0, SW, 1, o_zero(0), "rst_hold1");
        step(1, SW, 0, o_zero(0), "rst_state");
        step(1, SW, 0, o_fetch(0), "rst_fetch_after");
        step(1, R, 1, o_fetch(1), "rst_fetch_go");
        step(1, R, 0, o_zero(0), "rst_r_decode");
        step(1, R, 0, o_exec(3'b000, 2'b00), "rst_r_exec");
        step(1, R, 0, o_wb(1, 0), "rst_r_wb");

        // illegal opcode traps until reset
        step(1, BD, 1, o_fetch(1), "ill_fetch");
        step(1, BD, 1, o_zero(0), "ill_decode");
        for (int k = 0; k < 4; k++)
            step(1, BD, 1, o_zero(1), "ill_trap");
        step(0, BD, 1, o_zero(1), "ill_rst");
        step(1, R, 1, o_zero(0), "ill_cleared");
        step(1, R, 1, o_fetch(1), "ill_refetch");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
